// File: rtl/mmio_pwm_pkg.sv
// mmio_pwm_pkg: shared constants, register-select enum and address decode
// helper for the memory-mapped PWM responder.
//   OFF_*          byte offsets of the six registers inside the window
//   CTRL_EN_BIT    bit index of EN in CTRL
//   decode_reg()   window offset -> register select (byte lanes ignored)
package mmio_pwm_pkg;

  localparam int unsigned PWM_BITS_DEFAULT = 8;
  localparam int unsigned PRESCALE_BITS    = 16;
  localparam int unsigned NUM_CH           = 4;
  localparam int unsigned CTRL_EN_BIT      = 0;

  localparam logic [31:0] OFF_LED      = 32'h0000_0000;
  localparam logic [31:0] OFF_RED      = 32'h0000_0004;
  localparam logic [31:0] OFF_GREEN    = 32'h0000_0008;
  localparam logic [31:0] OFF_BLUE     = 32'h0000_000C;
  localparam logic [31:0] OFF_PRESCALE = 32'h0000_0010;
  localparam logic [31:0] OFF_CTRL     = 32'h0000_0014;

  typedef enum logic [2:0] {
    REG_LED,
    REG_RED,
    REG_GREEN,
    REG_BLUE,
    REG_PRESCALE,
    REG_CTRL,
    REG_NONE
  } pwm_reg_e;

  // Offset relative to the window base; anything unmapped decodes to REG_NONE.
  function automatic pwm_reg_e decode_reg(input logic [31:0] off);
    logic [31:0] word_off;
    word_off   = {off[31:2], 2'b00};
    decode_reg = REG_NONE;
    case (word_off)
      OFF_LED:      decode_reg = REG_LED;
      OFF_RED:      decode_reg = REG_RED;
      OFF_GREEN:    decode_reg = REG_GREEN;
      OFF_BLUE:     decode_reg = REG_BLUE;
      OFF_PRESCALE: decode_reg = REG_PRESCALE;
      OFF_CTRL:     decode_reg = REG_CTRL;
      default:      decode_reg = REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM output with double-buffered duty.
//   i_wr / i_wdata   bus write into the shadow (readback) duty
//   i_en             global enable; while low, active tracks shadow
//   i_period_end     period wrap; shadow is copied to active
//   i_period_cnt     shared period counter for the compare
//   o_shadow         shadow duty for bus readback
//   o_pin            registered pin, inverted when ACTIVE_LOW
module pwm_channel #(
  parameter int unsigned PWM_BITS   = 8,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_wr,
  input  logic [PWM_BITS-1:0] i_wdata,
  input  logic                i_en,
  input  logic                i_period_end,
  input  logic [PWM_BITS-1:0] i_period_cnt,
  output logic [PWM_BITS-1:0] o_shadow,
  output logic                o_pin
);

  logic [PWM_BITS-1:0] r_shadow;
  logic [PWM_BITS-1:0] r_active;
  logic                r_pin;

  // A write coinciding with period_end lands in the shadow while active
  // takes the old shadow, so it applies one wrap later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow <= '0;
      r_active <= '0;
      r_pin    <= ACTIVE_LOW;
    end else begin
      if (i_wr) r_shadow <= i_wdata;
      if (!i_en || i_period_end) r_active <= r_shadow;
      r_pin <= (i_en && (i_period_cnt < r_active)) ^ ACTIVE_LOW;
    end
  end

  assign o_shadow = r_shadow;
  assign o_pin    = r_pin;

endmodule

// File: rtl/mmio_pwm_responder.sv
// mmio_pwm_responder: data-bus slave driving led/red/green/blue with PWM.
//   clk, reset           clock, async active-high reset
//   req/we/addr/wdata    bus request, held until ack
//   rdata/ack            registered one-cycle response, rdata 0 outside ack
//   led/red/green/blue   PWM pins (RGB optionally active-low)
module mmio_pwm_responder
  import mmio_pwm_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'hFFFF_0000,
  parameter int unsigned PWM_BITS       = PWM_BITS_DEFAULT,
  parameter logic [15:0] PRESCALE_RESET = 16'd0,
  parameter bit          RGB_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  logic                     r_ack;
  logic [31:0]              r_rdata;
  logic [PRESCALE_BITS-1:0] r_prescale;
  logic [PRESCALE_BITS-1:0] r_pre_cnt;
  logic                     r_en;
  logic [PWM_BITS-1:0]      r_period_cnt;

  logic                w_accept;
  logic                w_wr;
  logic                w_tick;
  logic                w_period_end;
  pwm_reg_e            w_sel;
  logic [NUM_CH-1:0]   w_duty_wr;
  logic [NUM_CH-1:0]   w_pin;
  logic [PWM_BITS-1:0] w_shadow [NUM_CH];
  logic [31:0]         w_rd_val;
  logic                w_unused;

  // No new request is taken while ack is high.
  assign w_accept     = req && !r_ack;
  assign w_wr         = w_accept && we;
  assign w_sel        = decode_reg(addr - BASE_ADDR);
  assign w_tick       = r_en && (r_pre_cnt == r_prescale);
  assign w_period_end = w_tick && (r_period_cnt == '1);
  assign w_unused     = ^wdata[31:16];

  // Duty write strobes per channel.
  always_comb begin
    w_duty_wr = '0;
    if (w_wr) begin
      case (w_sel)
        REG_LED:   w_duty_wr[0] = 1'b1;
        REG_RED:   w_duty_wr[1] = 1'b1;
        REG_GREEN: w_duty_wr[2] = 1'b1;
        REG_BLUE:  w_duty_wr[3] = 1'b1;
        default:   w_duty_wr = '0;
      endcase
    end
  end

  // Readback mux, zero-extended; unmapped selects read 0.
  always_comb begin
    w_rd_val = '0;
    case (w_sel)
      REG_LED:      w_rd_val = 32'(w_shadow[0]);
      REG_RED:      w_rd_val = 32'(w_shadow[1]);
      REG_GREEN:    w_rd_val = 32'(w_shadow[2]);
      REG_BLUE:     w_rd_val = 32'(w_shadow[3]);
      REG_PRESCALE: w_rd_val = 32'(r_prescale);
      REG_CTRL:     w_rd_val = 32'(r_en);
      default:      w_rd_val = '0;
    endcase
  end

  // Bus handshake, control registers and the shared prescale/period counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ack        <= 1'b0;
      r_rdata      <= '0;
      r_prescale   <= PRESCALE_RESET;
      r_en         <= 1'b0;
      r_pre_cnt    <= '0;
      r_period_cnt <= '0;
    end else begin
      r_ack   <= w_accept;
      r_rdata <= (w_accept && !we) ? w_rd_val : '0;
      if (w_wr && (w_sel == REG_PRESCALE)) r_prescale <= wdata[PRESCALE_BITS-1:0];
      if (w_wr && (w_sel == REG_CTRL))     r_en       <= wdata[CTRL_EN_BIT];
      if (!r_en) begin
        r_pre_cnt    <= '0;
        r_period_cnt <= '0;
      end else if (w_tick) begin
        r_pre_cnt    <= '0;
        r_period_cnt <= r_period_cnt + 1'b1;
      end else begin
        // Past a lowered PRESCALE this wraps through 16 bits before ticking.
        r_pre_cnt <= r_pre_cnt + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_channel #(
      .PWM_BITS   (PWM_BITS),
      .ACTIVE_LOW ((i == 0) ? 1'b0 : RGB_ACTIVE_LOW)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .i_wr         (w_duty_wr[i]),
      .i_wdata      (wdata[PWM_BITS-1:0]),
      .i_en         (r_en),
      .i_period_end (w_period_end),
      .i_period_cnt (r_period_cnt),
      .o_shadow     (w_shadow[i]),
      .o_pin        (w_pin[i])
    );
  end

  assign ack   = r_ack;
  assign rdata = r_rdata;
  assign led   = w_pin[0];
  assign red   = w_pin[1];
  assign green = w_pin[2];
  assign blue  = w_pin[3];

endmodule

// File: tb/tb_mmio_pwm_responder.sv
// Bench for mmio_pwm_responder: register-map vector table, hand-written
// waveform / buffering / disable / reset sequences, and a randomized run
// against a period-arithmetic reference model.
module tb_mmio_pwm_responder;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset, req, we;
  logic [31:0] addr, wdata, rdata;
  logic        ack, led, red, green, blue;

  always #5 clk = ~clk;

  mmio_pwm_responder #(
    .BASE_ADDR(BASE), .PWM_BITS(8), .PRESCALE_RESET(16'd0), .RGB_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .led(led), .red(red), .green(green), .blue(blue)
  );

  typedef struct { int cyc; int ch; int val; } wr_t;
  typedef struct { logic w; logic [31:0] a; logic [31:0] d; logic [31:0] exp; } vec_t;

  wr_t  wlog[$];
  vec_t tbl[$];
  int   cyc = 0, n_cmp = 0, n_bad = 0;
  bit   mdl_on = 1'b0;
  int   me, mp;
  int   m_duty[4];
  bit   hs_on = 1'b0;
  int   hs_e, hs_len;
  int   hs_led[4], hs_red[4], hs_grn[4];
  logic trace[1024];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Shadow duty in force during cycle c, from the log of acknowledged writes.
  function automatic int shadow_at(int ch, int c);
    int v = 0;
    foreach (wlog[i]) if (wlog[i].ch == ch && wlog[i].cyc <= c) v = wlog[i].val;
    return v;
  endfunction

  // Pin level in cycle c, given enable acked in cycle me with prescale mp.
  function automatic logic exp_pin(int ch, int c);
    int t, len, cnt, k, ad;
    logic act;
    len = 256 * (mp + 1);
    t   = c - 1 - me;
    if (t < 0) act = 1'b0;
    else begin
      cnt = (t / (mp + 1)) % 256;
      k   = t / len;
      ad  = (k == 0) ? shadow_at(ch, me) : shadow_at(ch, me + len * k - 1);
      act = (cnt < ad);
    end
    return (ch == 0) ? act : !act;
  endfunction

  task automatic step();
    int t;
    @(posedge clk);
    #1;
    cyc++;
    if (mdl_on) begin
      chk("pin_led",   32'(led),   32'(exp_pin(0, cyc)));
      chk("pin_red",   32'(red),   32'(exp_pin(1, cyc)));
      chk("pin_green", 32'(green), 32'(exp_pin(2, cyc)));
      chk("pin_blue",  32'(blue),  32'(exp_pin(3, cyc)));
    end
    if (hs_on) begin
      t = cyc - 1 - hs_e;
      if (t >= 0 && t < 1024) trace[t] = led;
      if (t >= 0 && t < 4 * hs_len) begin
        hs_led[t / hs_len] += int'(led);
        hs_red[t / hs_len] += int'(!red);
        hs_grn[t / hs_len] += int'(!green);
      end
    end
  endtask

  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d, input int log_ch,
                     output logic [31:0] rd, output int ack_c);
    int n;
    if (ack) begin
      step();
      chk("ack_one_cycle", 32'(ack), 32'd0);
      chk("rdata_idle", rdata, 32'd0);
    end
    req = 1'b1; we = w; addr = a; wdata = d;
    step();
    n = 0;
    while (!ack && n < 8) begin step(); n++; end
    chk("ack_latency", 32'(n), 32'd0);
    rd = rdata;
    ack_c = cyc;
    if (w && log_ch >= 0) wlog.push_back('{ack_c, log_ch, int'(d[7:0])});
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d, output int ac);
    logic [31:0] r;
    bus(1'b1, BASE + off, d, (off < 32'd16) ? int'(off >> 2) : -1, r, ac);
  endtask

  task automatic rd(input logic [31:0] off, output logic [31:0] r);
    int ac;
    bus(1'b0, BASE + off, '0, -1, r, ac);
  endtask

  task automatic hs_start(input int e, input int len);
    hs_e = e; hs_len = len;
    for (int i = 0; i < 4; i++) begin hs_led[i] = 0; hs_red[i] = 0; hs_grn[i] = 0; end
    for (int i = 0; i < 1024; i++) trace[i] = 1'b0;
    hs_on = 1'b1;
  endtask

  function automatic int rnd_duty();
    case ($urandom_range(0, 7))
      0:       return 0;
      1:       return 255;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic rand_run(input int p);
    int ac, len, ch, v;
    logic [31:0] r, ex;
    mdl_on = 1'b0;
    wr(32'h14, 32'd0, ac);
    wlog.delete();
    mp = p;
    wr(32'h10, 32'(p), ac);
    for (int i = 0; i < 4; i++) begin
      v = rnd_duty(); wr(32'(i * 4), 32'(v), ac); m_duty[i] = v;
    end
    wr(32'h14, 32'd1, me);
    mdl_on = 1'b1;
    len = 256 * (p + 1);
    while (cyc < me + 4 * len) begin
      case ($urandom_range(0, 59))
        0, 1: begin
          ch = int'($urandom_range(0, 3)); v = rnd_duty();
          wr(32'(ch * 4), {$urandom_range(0, 255), 8'(v)}, ac); m_duty[ch] = v;
        end
        2: begin
          ch = int'($urandom_range(0, 5));
          rd(32'(ch * 4), r);
          ex = (ch < 4) ? 32'(m_duty[ch]) : (ch == 4) ? 32'(p) : 32'd1;
          chk("rand_readback", r, ex);
        end
        default: step();
      endcase
    end
    mdl_on = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, d;
    logic [31:0] r;
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    #12;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_rgb", 32'({red, green, blue}), 32'd7);
    @(negedge clk);
    reset = 1'b0;

    // Register map vectors: {we, addr, wdata, expected read data}.
    tbl.push_back('{1'b1, BASE + 32'h04, 32'h0000_005A, 32'h0});
    tbl.push_back('{1'b1, BASE + 32'h10, 32'h0000_1234, 32'h0});
    tbl.push_back('{1'b0, BASE + 32'h04, 32'h0,         32'h0000_005A});
    tbl.push_back('{1'b0, BASE + 32'h10, 32'h0,         32'h0000_1234});
    tbl.push_back('{1'b0, BASE + 32'h18, 32'h0,         32'h0});
    tbl.push_back('{1'b1, BASE + 32'h00, 32'h0000_0ABC, 32'h0});
    tbl.push_back('{1'b0, BASE + 32'h00, 32'h0,         32'h0000_00BC});
    tbl.push_back('{1'b0, BASE + 32'h03, 32'h0,         32'h0000_00BC});
    tbl.push_back('{1'b1, BASE + 32'h1C, 32'h0000_00FF, 32'h0});
    tbl.push_back('{1'b0, BASE + 32'h1C, 32'h0,         32'h0});
    tbl.push_back('{1'b1, BASE + 32'h0C, 32'h0000_0077, 32'h0});
    tbl.push_back('{1'b0, BASE + 32'h0C, 32'h0,         32'h0000_0077});
    tbl.push_back('{1'b0, BASE + 32'h08, 32'h0,         32'h0});
    tbl.push_back('{1'b1, 32'h0000_0004, 32'h0000_0011, 32'h0});
    tbl.push_back('{1'b0, BASE + 32'h04, 32'h0,         32'h0000_005A});
    tbl.push_back('{1'b0, 32'h0000_0004, 32'h0,         32'h0});
    tbl.push_back('{1'b1, BASE + 32'h14, 32'hFFFF_FFFF, 32'h0});
    tbl.push_back('{1'b0, BASE + 32'h14, 32'h0,         32'h0000_0001});
    tbl.push_back('{1'b1, BASE + 32'h14, 32'h0000_0000, 32'h0});
    tbl.push_back('{1'b0, BASE + 32'h14, 32'h0,         32'h0});
    tbl.push_back('{1'b1, BASE + 32'h10, 32'h0001_2345, 32'h0});
    tbl.push_back('{1'b0, BASE + 32'h10, 32'h0,         32'h0000_2345});
    foreach (tbl[i]) begin
      bus(tbl[i].w, tbl[i].a, tbl[i].d, -1, r, e);
      if (!tbl[i].w) chk($sformatf("tbl%0d_rdata", i), r, tbl[i].exp);
    end

    // Waveform and edge duties, PRESCALE 0.
    wr(32'h14, 0, e); wr(32'h00, 64, e); wr(32'h04, 255, e); wr(32'h08, 0, e);
    wr(32'h0C, 0, e); wr(32'h10, 0, e); wr(32'h14, 1, e);
    hs_start(e, 256);
    while (cyc < e + 512) step();
    hs_on = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("wave_led_high_p%0d", k), 32'(hs_led[k]), 32'd64);
      chk($sformatf("wave_red_low_p%0d", k), 32'(hs_red[k]), 32'd255);
      chk($sformatf("wave_green_low_p%0d", k), 32'(hs_grn[k]), 32'd0);
    end
    chk("wave_led_t0", 32'(trace[0]), 32'd1);
    chk("wave_led_t63", 32'(trace[63]), 32'd1);
    chk("wave_led_t64", 32'(trace[64]), 32'd0);
    chk("wave_led_t255", 32'(trace[255]), 32'd0);

    // LED duty 0 never lights.
    wr(32'h14, 0, e); wr(32'h00, 0, e); wr(32'h14, 1, e);
    hs_start(e, 256);
    while (cyc < e + 1024) step();
    hs_on = 1'b0;
    chk("duty0_led_high", 32'(hs_led[0] + hs_led[1] + hs_led[2] + hs_led[3]), 32'd0);

    // Double buffering: mid-period change, then a write on period_end.
    wr(32'h14, 0, e); wr(32'h00, 64, e); wr(32'h14, 1, e);
    hs_start(e, 256);
    while (cyc < e + 100) step();
    wr(32'h00, 128, d);
    while (cyc < e + 511) step();
    wr(32'h00, 200, d);
    while (cyc < e + 1024) step();
    hs_on = 1'b0;
    chk("dbuf_p0", 32'(hs_led[0]), 32'd64);
    chk("dbuf_p1", 32'(hs_led[1]), 32'd128);
    chk("dbuf_p2_on_wrap", 32'(hs_led[2]), 32'd128);
    chk("dbuf_p3", 32'(hs_led[3]), 32'd200);

    // Prescale 3, then disable and re-enable.
    wr(32'h14, 0, e); wr(32'h00, 2, e); wr(32'h04, 255, e); wr(32'h10, 3, e); wr(32'h14, 1, e);
    hs_start(e, 1024);
    while (cyc < e + 2048) step();
    hs_on = 1'b0;
    chk("pre_led_p0", 32'(hs_led[0]), 32'd8);
    chk("pre_led_p1", 32'(hs_led[1]), 32'd8);
    chk("pre_red_low_p0", 32'(hs_red[0]), 32'd1020);
    wr(32'h14, 0, d);
    step();
    chk("dis_led", 32'(led), 32'd0);
    chk("dis_rgb", 32'({red, green, blue}), 32'd7);
    wr(32'h14, 1, e);
    hs_start(e, 1024);
    while (cyc < e + 16) step();
    hs_on = 1'b0;
    for (int t = 0; t < 8; t++) chk($sformatf("reen_led_t%0d", t), 32'(trace[t]), 32'd1);
    chk("reen_led_t8", 32'(trace[8]), 32'd0);

    // Randomized runs against the period model.
    rand_run(0);
    rand_run(int'($urandom_range(1, 3)));

    // Reset while a read ack is pending.
    wr(32'h14, 0, e); wr(32'h00, 255, e); wr(32'h04, 255, e); wr(32'h10, 0, e); wr(32'h14, 1, e);
    repeat (5) step();
    req = 1'b1; we = 1'b0; addr = BASE + 32'h04;
    step();
    chk("pre_reset_ack", 32'(ack), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    chk("mid_rst_led", 32'(led), 32'd0);
    chk("mid_rst_rgb", 32'({red, green, blue}), 32'd7);
    @(negedge clk);
    req = 1'b0; addr = '0;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rd(32'(i * 4), r);
      chk($sformatf("post_rst_reg%0d", i), r, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mmio_pwm_responder.md
# mmio_pwm_responder

Memory-mapped responder that sits on the processor's data-memory bus beside data RAM and drives the board `led`, `red`, `green` and `blue` pins from `top`. Software stores duty, prescale and control values to it and may load them back. A shared free-running PWM counter generates glitch-free outputs, and each new duty takes effect at the next PWM period boundary.

## Interface
- `BASE_ADDR`, default 32'hFFFF_0000: word-aligned base of the 6-register window (offsets 0x00–0x14).
- `PWM_BITS`, default 8: duty and period counter width.
- `PRESCALE_RESET`, default 16'd0: reset value of the prescale register.
- `RGB_ACTIVE_LOW`, default 1: inverts `red`/`green`/`blue` at the pin; `led` is always active-high.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  1  bus request, held until `ack`.
- `we`  in  1  1 = write, 0 = read; valid with `req`.
- `addr`  in  32  byte address; bits [1:0] ignored.
- `wdata`  in  32  write data; only the low field width is stored.
- `rdata`  out  32  read data, zero-extended; valid only while `ack` = 1, else 0.
- `ack`  out  1  one-cycle response pulse.
- `led`, `red`, `green`, `blue`  out  1 each  PWM outputs.

## Operation
- Register map (offset: field):
  - 0x00 LED duty [PWM_BITS-1:0]
  - 0x04 RED duty
  - 0x08 GREEN duty
  - 0x0C BLUE duty
  - 0x10 PRESCALE [15:0]
  - 0x14 CTRL bit0 = EN
- Addresses in the window but unmapped, and addresses outside the window while `req` = 1: the bus is still acked, writes are ignored, reads return 0.
- Bus handshake:
  - `req` sampled high with `ack` = 0 latches the transaction.
  - `ack` = 1 on the next cycle for exactly 1 cycle; write side effects are visible from that cycle.
  - No request is accepted during the `ack` cycle, so back-to-back transactions take 2 cycles each.
- Prescaler: counts 0..PRESCALE; `tick` fires when the count equals PRESCALE, then the count returns to 0. PRESCALE = 0 means a tick every cycle.
- Period counter: PWM_BITS wide, increments on `tick`, wraps from 2^PWM_BITS−1 to 0. The wrap cycle is `period_end`.
- Duty buffering: each channel has a shadow register (bus-visible, readback) and an active register (used for compare). Shadow copies to active on `period_end`.
- A duty write in the same cycle as `period_end` is not applied; the old shadow is loaded and the new value applies at the following wrap.
- Channel output (pre-inversion) = EN && (period_cnt < active_duty):
  - duty 0: constantly off.
  - duty 2^PWM_BITS−1: on for 255 of 256 counts.
- EN = 0: prescaler and period counter held at 0, active ← shadow every cycle, all outputs at inactive level.
- EN 0→1: counting starts from 0 on the next cycle.
- PRESCALE write: takes effect immediately. If the current prescale count already exceeds the new value, it continues to wrap at 16 bits before ticking.
- Reset (any time, including mid-transaction): all state returns to reset values at once; any pending `ack` is dropped.
- Reset values:
  - All duties 0, PRESCALE = PRESCALE_RESET, EN = 0, counters 0.
  - `ack` = 0, `rdata` = 0, `led` = 0.
  - `red`/`green`/`blue` = 1 when RGB_ACTIVE_LOW = 1, else 0.

## Timing
- Bus latency: 1 cycle from `req` sampled to `ack`; `rdata` is registered.
- Outputs are registered: a pin reflects the compare of period_cnt value N one cycle after the counter holds N.
- With EN = 1, PRESCALE = 0, duty D: after each wrap, the pin is active for D cycles and inactive for 2^PWM_BITS−D cycles. The period is 2^PWM_BITS × (PRESCALE+1) cycles.
- A write to a duty reaches the pin no earlier than the first `period_end` after `ack`, plus 1 cycle.

## Structure
- Package `mmio_pwm_pkg`: register offset localparams (OFF_LED … OFF_CTRL), CTRL bit index, default PWM width, and a `pwm_reg_e` enum for decoded register select.
- Sub-module `pwm_channel`: shadow/active duty registers, compare, output register and polarity inversion; instantiated 4×.
- Top level of this block: bus decode, handshake, prescaler, period counter.

## Test plan
- Reset behaviour: assert `reset` mid-read with `ack` pending → `ack` = 0, `rdata` = 0, `led` = 0, `red`/`green`/`blue` = 1, all readbacks 0 after release.
- Bus readback: write 0x5A to 0x04 and 0x1234 to 0x10, then read both → `ack` exactly 1 cycle after each `req`, rdata 0x0000005A and 0x00001234. Read 0x18 → 0.
- Duty waveform: LED duty 64, PRESCALE 0, EN 1 → `led` high 64 cycles, low 192 cycles, repeating every 256.
- Edge duties: duty 0 → `led` never high over 1024 cycles. RED duty 255 → `red` low 255 of every 256 cycles.
- Double-buffering: change LED duty 64→128 mid-period → current period keeps 64 high cycles; the next period has 128. A write landing exactly on `period_end` applies one period later.
- Prescale and disable: PRESCALE 3, duty 2 → `led` high 8 cycles per 1024-cycle period. Clear EN → all outputs inactive on the next cycle and the counters read back as restarting from 0 when re-enabled.
